// File: rtl/analog_scan_seq.sv
// Time-shares the analog pins with one comparator. Each selected channel gets
// break-before-make dead time, a settle interval, a one-cycle sample strobe and a result capture.
module analog_scan_seq #(
   parameter int NCH      = 6,
   parameter int DEAD_CYC = 2,
   parameter int SETTLE_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                start,
   input  logic                cont,
   input  logic [NCH-1:0]      ch_mask,
   input  logic [SETTLE_W-1:0] settle_cyc,
   input  logic                cmp_in,
   output logic [NCH-1:0]      sw_en,
   output logic                sample,
   output logic [NCH-1:0]      result,
   output logic [2:0]          cur_ch,
   output logic                busy,
   output logic                done
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DEAD   = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_SAMPLE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam int DW = $clog2(DEAD_CYC + 1);
   localparam int CW = (SETTLE_W > DW) ? SETTLE_W : DW;

   logic [2:0]          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NCH-1:0]      mask_q, mask_d;
   logic [SETTLE_W-1:0] set_q, set_d;
   logic [2:0]          cur_ch_q, cur_ch_d;
   logic [NCH-1:0]      sw_en_q, sw_en_d;
   logic                sample_q, sample_d;
   logic [NCH-1:0]      result_q, result_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [NCH-1:0]      hi_bits;
   logic [SETTLE_W-1:0] new_set;

   function automatic logic [2:0] low_bit(input logic [NCH-1:0] m);
      logic [2:0] r;
      r = '0;
      for (int unsigned i = NCH; i > 0; i--) begin
         if (m[i-1]) r = 3'(i - 1);
      end
      return r;
   endfunction

   // Mask bits strictly above the current channel: the upward, non-wrapping search set.
   function automatic logic [NCH-1:0] above(input logic [NCH-1:0] m, input logic [2:0] c);
      logic [NCH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         r[i] = m[i] && (i > 32'(c));
      end
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mask_d   = mask_q;
      set_d    = set_q;
      cur_ch_d = cur_ch_q;
      result_d = result_q;
      hi_bits  = above(mask_q, cur_ch_q);
      new_set  = (settle_cyc == '0) ? SETTLE_W'(1) : settle_cyc;

      case (state_q)
         ST_IDLE: begin
            if (ena && start && (ch_mask != '0)) begin
               mask_d   = ch_mask;
               set_d    = new_set;
               cur_ch_d = low_bit(ch_mask);
               cnt_d    = CW'(DEAD_CYC - 1);
               state_d  = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(set_q - SETTLE_W'(1));
               state_d = ST_SETTLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) state_d = ST_SAMPLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         ST_SAMPLE: begin
            result_d[cur_ch_q] = cmp_in;
            if (hi_bits != '0) begin
               cur_ch_d = low_bit(hi_bits);
               cnt_d    = CW'(DEAD_CYC - 1);
               state_d  = ST_DEAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (cont && ena && (ch_mask != '0)) begin
               mask_d   = ch_mask;
               set_d    = new_set;
               cur_ch_d = low_bit(ch_mask);
               cnt_d    = CW'(DEAD_CYC - 1);
               state_d  = ST_DEAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!ena && (state_q != ST_IDLE)) state_d = ST_IDLE;

      // Outputs are decoded from the next state so the registered value matches the state it labels.
      sw_en_d  = ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) ? (NCH'(1) << cur_ch_d) : '0;
      sample_d = (state_d == ST_SAMPLE);
      busy_d   = (state_d == ST_DEAD) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
      done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mask_q   <= '0;
         set_q    <= SETTLE_W'(1);
         cur_ch_q <= '0;
         sw_en_q  <= '0;
         sample_q <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mask_q   <= mask_d;
         set_q    <= set_d;
         cur_ch_q <= cur_ch_d;
         sw_en_q  <= sw_en_d;
         sample_q <= sample_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sw_en  = sw_en_q;
   assign sample = sample_q;
   assign result = result_q;
   assign cur_ch = cur_ch_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_analog_scan_seq.sv
// Bench for analog_scan_seq: a per-cycle expected timeline is built from the channel
// list of each pass and compared against the DUT outputs every cycle.
module tb_analog_scan_seq;

   localparam int NCH  = 6;
   localparam int DEAD = 2;

   logic           clk = 1'b0;
   logic           rst_n, ena, start, cont, cmp_in;
   logic [NCH-1:0] ch_mask, sw_en, result, cmp_val;
   logic [7:0]     settle_cyc;
   logic           sample, busy, done;
   logic [2:0]     cur_ch;

   analog_scan_seq #(.NCH(NCH), .DEAD_CYC(DEAD), .SETTLE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont),
      .ch_mask(ch_mask), .settle_cyc(settle_cyc), .cmp_in(cmp_in),
      .sw_en(sw_en), .sample(sample), .result(result), .cur_ch(cur_ch),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Comparator model: the decision of whichever pin is currently connected.
   assign cmp_in = |(sw_en & cmp_val);

   typedef struct {
      logic [5:0] sw;
      logic       samp;
      logic       busy;
      logic       done;
      logic [2:0] ch;
      logic       chv;
      logic [5:0] res;
   } exp_t;

   exp_t       q[$];
   int         pos;
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [5:0] model_res = '0;
   logic [5:0] last_sw   = '0;
   int         zero_run  = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, pos);
   endtask

   task automatic push_e(input logic [5:0] sw, input logic samp, input logic b, input logic d,
                         input logic [2:0] ch, input logic chv);
      exp_t e;
      e.sw = sw; e.samp = samp; e.busy = b; e.done = d; e.ch = ch; e.chv = chv; e.res = model_res;
      q.push_back(e);
   endtask

   task automatic begin_plan();
      q.delete();
      pos = 0;
   endtask

   // One pass: every selected channel, lowest first, gets dead, settle and sample cycles.
   task automatic plan_pass(input logic [5:0] m, input int settle, input logic [5:0] cv);
      int s;
      s = (settle == 0) ? 1 : settle;
      for (int ch = 0; ch < NCH; ch++) begin
         if (m[ch]) begin
            for (int k = 0; k < DEAD; k++) push_e('0, 1'b0, 1'b1, 1'b0, 3'(ch), 1'b1);
            for (int k = 0; k < s; k++)    push_e(6'(1 << ch), 1'b0, 1'b1, 1'b0, 3'(ch), 1'b1);
            push_e(6'(1 << ch), 1'b1, 1'b1, 1'b0, 3'(ch), 1'b1);
            model_res[ch] = cv[ch];
         end
      end
      push_e('0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
   endtask

   task automatic plan_idle(input int n);
      for (int k = 0; k < n; k++) push_e('0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic check_cycle(input exp_t e);
      chk("sw_en",  {2'b0, sw_en},  {2'b0, e.sw});
      chk("sample", {7'b0, sample}, {7'b0, e.samp});
      chk("busy",   {7'b0, busy},   {7'b0, e.busy});
      chk("done",   {7'b0, done},   {7'b0, e.done});
      chk("result", {2'b0, result}, {2'b0, e.res});
      if (e.chv) chk("cur_ch", {5'b0, cur_ch}, {5'b0, e.ch});
      chk("onehot0", {7'b0, $onehot0(sw_en)}, 8'd1);
      if (sw_en == '0) begin
         zero_run++;
      end else begin
         if ((last_sw != '0) && (sw_en != last_sw))
            chk("bbm_gap", {7'b0, (zero_run >= DEAD)}, 8'd1);
         last_sw  = sw_en;
         zero_run = 0;
      end
   endtask

   task automatic play(input int upto);
      while (pos < upto) begin
         @(negedge clk);
         check_cycle(q[pos]);
         pos++;
      end
   endtask

   task automatic launch(input logic [5:0] m, input logic [7:0] settle, input logic [5:0] cv);
      ch_mask    = m;
      settle_cyc = settle;
      cmp_val    = cv;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin
      logic [5:0] m, cv;
      int         s;
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont = 1'b0;
      ch_mask = '0; settle_cyc = '0; cmp_val = '0;
      #12;
      chk("rst_sw_en",  {2'b0, sw_en},  8'd0);
      chk("rst_result", {2'b0, result}, 8'd0);
      chk("rst_flags",  {4'b0, sample, busy, done, 1'b0}, 8'd0);
      chk("rst_cur_ch", {5'b0, cur_ch}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single pass with a stray start pulse in cycle 9.
      begin_plan();
      plan_pass(6'b100101, 3, 6'b000100);
      plan_idle(3);
      launch(6'b100101, 8'd3, 6'b000100);
      play(9);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      play(q.size());

      // Empty mask is ignored.
      begin_plan();
      plan_idle(4);
      launch(6'b000000, 8'd3, 6'b111111);
      play(q.size());

      // Zero settle behaves as one cycle.
      begin_plan();
      plan_pass(6'b000010, 0, 6'b000010);
      plan_idle(2);
      launch(6'b000010, 8'd0, 6'b000010);
      play(q.size());

      // Abort with ena low in cycle 10.
      begin_plan();
      plan_pass(6'b100101, 3, 6'b111111);
      launch(6'b100101, 8'd3, 6'b111111);
      play(10);
      ena = 1'b0;
      while (q.size() > 10) void'(q.pop_back());
      model_res = q[9].res;
      plan_idle(3);
      play(q.size());
      ena = 1'b1;

      // Continuous mode with a mask change mid-pass.
      cv = 6'($urandom);
      cont = 1'b1;
      begin_plan();
      plan_pass(6'b000011, 3, cv);
      plan_pass(6'b100000, 3, cv);
      plan_idle(2);
      launch(6'b000011, 8'd3, cv);
      play(5);
      ch_mask = 6'b100000;
      play(16);
      cont = 1'b0;
      play(q.size());

      for (int k = 0; k < 8; k++) begin
         m  = 6'($urandom_range(1, 63));
         s  = $urandom_range(0, 5);
         cv = 6'($urandom);
         begin_plan();
         plan_pass(m, s, cv);
         plan_idle(2);
         launch(m, 8'(s), cv);
         play(q.size());
      end

      // Asynchronous reset in the middle of SETTLE on channel 2.
      begin_plan();
      plan_pass(6'b000100, 3, 6'b000100);
      launch(6'b000100, 8'd3, 6'b000100);
      play(4);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_sw_en",  {2'b0, sw_en},  8'd0);
      chk("arst_result", {2'b0, result}, 8'd0);
      chk("arst_flags",  {4'b0, sample, busy, done, 1'b0}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
